rst_seq_ctrl: RTL

//  Power-up / recovery reset sequencer, downstream of the system clock/reset index stage.

---
 rtl/rst_seq_ctrl_pkg.sv | 20 ++
 rtl/rst_seq_ctrl_sync_2ff.sv | 27 ++
 rtl/rst_seq_ctrl.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/rst_seq_ctrl_pkg.sv
// rst_seq_ctrl_pkg: shared sequencer state encoding and 50 MHz default timing.
`default_nettype none

package rst_seq_ctrl_pkg;

   typedef enum logic [2:0] {
      ST_WAIT_LOCK = 3'd0,
      ST_RELEASE   = 3'd1,
      ST_WAIT_ACK  = 3'd2,
      ST_DONE      = 3'd3,
      ST_ERROR     = 3'd4
   } seq_state_t;

   localparam logic [19:0] DEF_STAGE_DLY   = 20'd5000;
   localparam logic [19:0] DEF_ACK_TIMEOUT = 20'd500000;
   localparam logic [7:0]  DEF_LOCK_FILT   = 8'd64;

endpackage

`default_nettype wire

// File: rtl/rst_seq_ctrl_sync_2ff.sv
// rst_seq_ctrl_sync_2ff: two-flop synchroniser for asynchronous level inputs.
`default_nettype none

module rst_seq_ctrl_sync_2ff #(
   parameter int WIDTH = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] i_d,
   output logic [WIDTH-1:0] o_q
);

   logic [WIDTH-1:0] r_meta;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_meta <= '0;
         o_q    <= '0;
      end else begin
         r_meta <= i_d;
         o_q    <= r_meta;
      end
   end

endmodule

`default_nettype wire

// File: rtl/rst_seq_ctrl.sv
// rst_seq_ctrl: releases NUM_STAGES subsystem resets in order after PLL lock,
// waiting for each stage's init-done handshake with a timeout.
`default_nettype none

module rst_seq_ctrl
   import rst_seq_ctrl_pkg::*;
#(
   parameter int               NUM_STAGES  = 4,
   parameter int               CNT_W       = 20,
   parameter logic [CNT_W-1:0] STAGE_DLY   = CNT_W'(DEF_STAGE_DLY),
   parameter logic [CNT_W-1:0] ACK_TIMEOUT = CNT_W'(DEF_ACK_TIMEOUT),
   parameter logic [7:0]       LOCK_FILT   = DEF_LOCK_FILT
) (
   input  logic                  clk_50m,
   input  logic                  rst_n,
   input  logic                  pll_locked,
   input  logic                  sw_rst_req,
   input  logic [NUM_STAGES-1:0] stage_done,
   output logic [NUM_STAGES-1:0] stage_rst_n,
   output logic                  seq_done,
   output logic                  seq_err,
   output logic [2:0]            err_stage
);

   logic                  w_lock_s;
   logic [NUM_STAGES-1:0] w_done_s;
   logic                  w_done_cur;
   logic                  w_last_stage;

   seq_state_t            r_state;
   logic [CNT_W-1:0]      r_cnt;
   logic [7:0]            r_filt;
   logic [2:0]            r_idx;
   logic [NUM_STAGES-1:0] r_rel;
   logic                  r_seq_done;
   logic                  r_seq_err;
   logic [2:0]            r_err_stage;

   rst_seq_ctrl_sync_2ff #(.WIDTH(1)) u_lock_sync (
      .clk   (clk_50m),
      .rst_n (rst_n),
      .i_d   (pll_locked),
      .o_q   (w_lock_s)
   );

   rst_seq_ctrl_sync_2ff #(.WIDTH(NUM_STAGES)) u_done_sync (
      .clk   (clk_50m),
      .rst_n (rst_n),
      .i_d   (stage_done),
      .o_q   (w_done_s)
   );

   always_comb begin
      w_done_cur = 1'b0;
      for (int i = 0; i < NUM_STAGES; i++) begin
         if (3'(i) == r_idx) w_done_cur = w_done_s[i];
      end
   end

   assign w_last_stage = (r_idx == 3'(NUM_STAGES - 1));

   always_ff @(posedge clk_50m or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= ST_WAIT_LOCK;
         r_cnt       <= '0;
         r_filt      <= '0;
         r_idx       <= '0;
         r_rel       <= '0;
         r_seq_done  <= 1'b0;
         r_seq_err   <= 1'b0;
         r_err_stage <= '0;
      end else if (sw_rst_req) begin
         r_state     <= ST_WAIT_LOCK;
         r_cnt       <= '0;
         r_filt      <= '0;
         r_idx       <= '0;
         r_rel       <= '0;
         r_seq_done  <= 1'b0;
         r_seq_err   <= 1'b0;
         r_err_stage <= '0;
      end else if (r_state != ST_WAIT_LOCK && !w_lock_s) begin
         // Lock loss: error status survives so software can still inspect it.
         r_state    <= ST_WAIT_LOCK;
         r_cnt      <= '0;
         r_filt     <= '0;
         r_idx      <= '0;
         r_rel      <= '0;
         r_seq_done <= 1'b0;
      end else begin
         case (r_state)
            ST_WAIT_LOCK: begin
               if (!w_lock_s) begin
                  r_filt <= '0;
               end else if (r_filt == LOCK_FILT - 8'd1) begin
                  r_filt  <= '0;
                  r_cnt   <= '0;
                  r_idx   <= '0;
                  r_state <= ST_RELEASE;
               end else begin
                  r_filt <= r_filt + 8'd1;
               end
            end
            ST_RELEASE: begin
               if (r_cnt == STAGE_DLY - 1'b1) begin
                  for (int i = 0; i < NUM_STAGES; i++) begin
                     if (3'(i) == r_idx) r_rel[i] <= 1'b1;
                  end
                  r_cnt   <= '0;
                  r_state <= ST_WAIT_ACK;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            ST_WAIT_ACK: begin
               if (w_done_cur) begin
                  r_cnt <= '0;
                  if (w_last_stage) begin
                     // A clean completion supersedes any error left from an earlier run.
                     r_seq_done <= 1'b1;
                     r_seq_err  <= 1'b0;
                     r_state    <= ST_DONE;
                  end else begin
                     r_idx   <= r_idx + 3'd1;
                     r_state <= ST_RELEASE;
                  end
               end else if (r_cnt == ACK_TIMEOUT - 1'b1) begin
                  for (int i = 0; i < NUM_STAGES; i++) begin
                     if (3'(i) >= r_idx) r_rel[i] <= 1'b0;
                  end
                  r_seq_err   <= 1'b1;
                  r_err_stage <= r_idx;
                  r_cnt       <= '0;
                  r_state     <= ST_ERROR;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   assign stage_rst_n = r_rel;
   assign seq_done    = r_seq_done;
   assign seq_err     = r_seq_err;
   assign err_stage   = r_err_stage;

endmodule

`default_nettype wire
